// File: rtl/bpred_pkg.sv
// Shared types and the miss-compare rule for the execute-side branch resolution unit.
package bpred_pkg;

    localparam int BIMODAL_W = 12;
    localparam int ADDR_W    = 32;

    typedef struct packed {
        logic [ADDR_W-1:0]    pc4;
        logic                 p_dir;
        logic [ADDR_W-1:0]    p_target;
        logic [BIMODAL_W-1:0] bimodal;
    } bpred_entry_t;

    localparam int ENTRY_W = $bits(bpred_entry_t);

    // The target only matters when the branch was actually taken.
    function automatic logic bpred_miss(input logic              p_dir,
                                        input logic [ADDR_W-1:0] p_target,
                                        input logic              dir,
                                        input logic [ADDR_W-1:0] target);
        return (p_dir != dir) | (dir & (p_target != target));
    endfunction

endpackage

// File: rtl/bpred_resolve_fifo.sv
// Circular prediction queue with push, pop and clear; clear wins over both.
// Latency: push visible at head the cycle after the write edge; no write-to-read bypass.
// Backpressure: push while full is accepted only together with a pop, otherwise ignored.
module bpred_resolve_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 77
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)
                count <= count + (PTR_W+1)'(1);
            else if (!do_push && do_pop)
                count <= count - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/bpred_resolve.sv
// Queues fetch-time predictions and resolves the oldest against execute, driving predictor update and flush.
// Latency: resolve in cycle N gives update/miss/flush/redirect registered at N+1.
// Backpressure: none upstream; overflow/underflow are dropped and flagged sticky, stall freezes everything.
module bpred_resolve
    import bpred_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  soin_bpredictor_stall,
    input  logic                  fetch_push,
    input  logic [ADDR_W-1:0]     fetch_PC4,
    input  logic                  fetch_p_dir,
    input  logic [ADDR_W-1:0]     fetch_p_target,
    input  logic [BIMODAL_W-1:0]  fetch_bimodal,
    input  logic                  exec_resolve,
    input  logic                  exec_dir,
    input  logic [ADDR_W-1:0]     exec_target,
    output logic                  execute_bpredictor_update,
    output logic [ADDR_W-1:0]     execute_bpredictor_PC4,
    output logic [ADDR_W-1:0]     execute_bpredictor_target,
    output logic                  execute_bpredictor_dir,
    output logic                  execute_bpredictor_miss,
    output logic [BIMODAL_W-1:0]  execute_bpredictor_bimodal,
    output logic                  resolve_flush,
    output logic [ADDR_W-1:0]     resolve_redirect_PC,
    output logic                  q_full,
    output logic                  q_empty,
    output logic                  err_overflow,
    output logic                  err_underflow,
    output logic [CNT_W-1:0]      stat_branches,
    output logic [CNT_W-1:0]      stat_misses
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    bpred_entry_t     push_entry;
    bpred_entry_t     head;
    logic [PTR_W:0]   q_count;
    logic             active;
    logic             q_pop;
    logic             q_push;
    logic             q_clear;
    logic             miss_now;
    logic             push_req;
    logic             overflow_now;
    logic             underflow_now;

    assign push_entry = '{pc4: fetch_PC4, p_dir: fetch_p_dir,
                          p_target: fetch_p_target, bimodal: fetch_bimodal};

    assign active   = ~soin_bpredictor_stall;
    assign q_pop    = active & exec_resolve & ~q_empty;
    assign miss_now = bpred_miss(head.p_dir, head.p_target, exec_dir, exec_target);
    assign q_clear  = q_pop & miss_now;

    // Anything fetched during the miss cycle or the flush cycle is wrong-path.
    assign push_req      = active & fetch_push & ~q_clear & ~resolve_flush;
    assign q_push        = push_req;
    assign overflow_now  = push_req & q_full & ~q_pop;
    assign underflow_now = active & exec_resolve & (q_count == '0);

    bpred_resolve_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .clear (q_clear),
        .wdata (push_entry),
        .rdata (head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            execute_bpredictor_update  <= 1'b0;
            execute_bpredictor_PC4     <= '0;
            execute_bpredictor_target  <= '0;
            execute_bpredictor_dir     <= 1'b0;
            execute_bpredictor_miss    <= 1'b0;
            execute_bpredictor_bimodal <= '0;
            resolve_flush              <= 1'b0;
            resolve_redirect_PC        <= '0;
        end else if (!active) begin
            execute_bpredictor_update  <= 1'b0;
            execute_bpredictor_miss    <= 1'b0;
            resolve_flush              <= 1'b0;
        end else begin
            execute_bpredictor_update  <= q_pop;
            execute_bpredictor_miss    <= q_clear;
            resolve_flush              <= q_clear;
            if (q_pop) begin
                execute_bpredictor_PC4     <= head.pc4;
                execute_bpredictor_target  <= exec_target;
                execute_bpredictor_dir     <= exec_dir;
                execute_bpredictor_bimodal <= head.bimodal;
            end
            if (q_clear)
                resolve_redirect_PC <= exec_dir ? exec_target : head.pc4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            stat_branches <= '0;
            stat_misses   <= '0;
        end else begin
            if (overflow_now)
                err_overflow <= 1'b1;
            if (underflow_now)
                err_underflow <= 1'b1;
            if (q_pop && stat_branches != CNT_MAX)
                stat_branches <= stat_branches + CNT_W'(1);
            if (q_clear && stat_misses != CNT_MAX)
                stat_misses <= stat_misses + CNT_W'(1);
        end
    end

endmodule
